cam_fb_read_arb: RTL and testbench

Two-port read arbiter for the camera frame buffer. The frame buffer exposes a single synchronous read port in the `mem_clk` domain: `fb_addr` in, `fb_q[8:0]` out. This block shares that port between two requesters: the display scan-out (`disp`), which has priority, and the key/hand-detection engine (`proc`), which is starvation-guarded. It sits between the frame buffer and both consumers, registers the address, tracks in-flight reads with a tag pipeline, and steers returned pixels to the requester that issued them.

---
 rtl/cam_fb_read_arb.sv | 106 ++++++++++
 tb/tb_cam_fb_read_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_fb_read_arb.sv
// Two-port read arbiter sharing the camera frame-buffer read port between display (priority) and proc.
// Define CAM_FB_ARB_STARVE_GUARD_EN to add the proc starvation counter and forced grant.
module cam_fb_read_arb #(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        mem_clk,
  input  logic        rst,
  input  logic        disp_req,
  input  logic [31:0] disp_addr,
  output logic        disp_gnt,
  output logic        disp_valid,
  output logic [8:0]  disp_q,
  input  logic        proc_req,
  input  logic [31:0] proc_addr,
  output logic        proc_gnt,
  output logic        proc_valid,
  output logic [8:0]  proc_q,
  input  logic        proc_hold,
  output logic [31:0] fb_addr,
  input  logic [8:0]  fb_q
);

  typedef enum logic [1:0] {IDLE = 2'd0, DISP = 2'd1, PROC = 2'd2} gnt_st_t;

  gnt_st_t    st;
  logic       proc_ok;
  logic       force_proc;
  logic [1:0] head;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("cam_fb_read_arb: MEM_LAT must be 1..4");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("cam_fb_read_arb: STARVE_LIMIT must be 1..255");
    end
  endgenerate

  assign proc_ok = rst & proc_req & ~proc_hold;

`ifdef CAM_FB_ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt;

  assign force_proc = proc_ok & (starve_cnt >= 8'(STARVE_LIMIT));

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst)                                    starve_cnt <= '0;
    else if (proc_gnt || !proc_req || proc_hold) starve_cnt <= '0;
    else if (starve_cnt != 8'hff)                starve_cnt <= starve_cnt + 8'd1;
  end
`else
  assign force_proc = 1'b0;
`endif

  assign disp_gnt = rst & disp_req & ~force_proc;
  assign proc_gnt = proc_ok & (force_proc | ~disp_req);

  // st doubles as the first tag stage: it is the grant type seen by the memory this cycle
  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      fb_addr <= '0;
    end else if (disp_gnt) begin
      st      <= DISP;
      fb_addr <= disp_addr;
    end else if (proc_gnt) begin
      st      <= PROC;
      fb_addr <= proc_addr;
    end else begin
      st      <= IDLE;
    end
  end

  generate
    if (MEM_LAT == 1) begin : g_l1
      assign head = st;
    end else begin : g_ln
      logic [MEM_LAT-1:1][1:0] sh;
      always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) sh <= '0;
        else begin
          sh[1] <= st;
          for (int k = 2; k < MEM_LAT; k++) sh[k] <= sh[k-1];
        end
      end
      assign head = sh[MEM_LAT-1];
    end
  endgenerate

  // head tag marks the cycle fb_q carries that read's data
  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      disp_valid <= 1'b0;
      proc_valid <= 1'b0;
      disp_q     <= '0;
      proc_q     <= '0;
    end else begin
      disp_valid <= (head == DISP);
      proc_valid <= (head == PROC);
      if (head == DISP) disp_q <= fb_q;
      if (head == PROC) proc_q <= fb_q;
    end
  end

endmodule

// File: tb/tb_cam_fb_read_arb.sv
// Bench for cam_fb_read_arb: vector table, directed corner sequences and a random run against a return-queue model.
module tb_cam_fb_read_arb;
  localparam int LAT   = 1;
  localparam int LIMIT = 8;
`ifdef CAM_FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        mem_clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_req = 1'b0, proc_req = 1'b0, proc_hold = 1'b0;
  logic [31:0] disp_addr = '0, proc_addr = '0;
  logic        disp_gnt, disp_valid, proc_gnt, proc_valid;
  logic [8:0]  disp_q, proc_q, fb_q;
  logic [31:0] fb_addr;
  logic        ovr_en = 1'b0;
  logic [8:0]  ovr_val = '0;

  int total = 0, bad = 0, cyc = 0;

  function automatic logic [8:0] mem_rd(input logic [31:0] a);
    return a[8:0] ^ a[17:9] ^ a[26:18];
  endfunction

  assign fb_q = ovr_en ? ovr_val : mem_rd(fb_addr);

  always #5 mem_clk = ~mem_clk;

  cam_fb_read_arb #(.MEM_LAT(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .mem_clk(mem_clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_q(disp_q),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_gnt(proc_gnt),
    .proc_valid(proc_valid), .proc_q(proc_q), .proc_hold(proc_hold),
    .fb_addr(fb_addr), .fb_q(fb_q)
  );

  typedef struct { int due; bit who; logic [8:0] data; } ret_t;
  ret_t        rq[$];
  int          cnt = 0;
  logic [8:0]  m_dq = '0, m_pq = '0;
  logic [31:0] m_addr = '0;
  bit          last_dg = 0, last_pg = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Called mid-cycle: compare against the model, advance it, move to next cycle.
  task automatic step();
    bit frc, dg, pg, dv, pv;
    frc = 0; dg = 0; pg = 0; dv = 0; pv = 0;
    if (!rst) begin
      rq.delete(); cnt = 0; m_dq = '0; m_pq = '0; m_addr = '0;
    end else begin
      frc = GUARD && cnt >= LIMIT && proc_req && !proc_hold;
      dg  = disp_req && !frc;
      pg  = proc_req && !proc_hold && !dg;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].who) begin pv = 1; m_pq = rq[0].data; end
        else           begin dv = 1; m_dq = rq[0].data; end
        void'(rq.pop_front());
      end
    end
    chk("disp_gnt", 32'(disp_gnt), 32'(dg));
    chk("proc_gnt", 32'(proc_gnt), 32'(pg));
    chk("disp_valid", 32'(disp_valid), 32'(dv));
    chk("proc_valid", 32'(proc_valid), 32'(pv));
    chk("disp_q", 32'(disp_q), 32'(m_dq));
    chk("proc_q", 32'(proc_q), 32'(m_pq));
    chk("fb_addr", fb_addr, m_addr);
    if (rst) begin
      foreach (rq[i]) if (rq[i].due == cyc + 1) rq[i].data = fb_q;
      if (dg) begin rq.push_back('{due: cyc + LAT + 1, who: 1'b0, data: 9'h0}); m_addr = disp_addr; end
      if (pg) begin rq.push_back('{due: cyc + LAT + 1, who: 1'b1, data: 9'h0}); m_addr = proc_addr; end
      if (pg || !proc_req || proc_hold) cnt = 0;
      else if (cnt < 255) cnt++;
    end
    last_dg = dg; last_pg = pg;
    cyc++;
    @(posedge mem_clk); #1;
  endtask

  task automatic tick();
    #4; step();
  endtask

  task automatic drv(input bit dr, input logic [31:0] da, input bit pr, input logic [31:0] pa, input bit h);
    disp_req = dr; disp_addr = da; proc_req = pr; proc_addr = pa; proc_hold = h;
  endtask

  typedef struct { bit dr; logic [31:0] da; bit pr; logic [31:0] pa; bit h; bit edg; bit epg; } vec_t;
  vec_t tv[6];

  initial begin
    int npg, first, second, seen, nv;
    bit dr, pr, h;
    logic [31:0] da, pa;

    tv[0] = '{0, 32'h0,         0, 32'h0,         0, 0, 0};
    tv[1] = '{1, 32'h0000_0155, 0, 32'h0,         0, 1, 0};
    tv[2] = '{0, 32'h0,         1, 32'h0003_00AA, 0, 0, 1};
    tv[3] = '{1, 32'h0000_0155, 1, 32'h0003_00AA, 0, 1, 0};
    tv[4] = '{0, 32'h0,         1, 32'h0003_00AA, 1, 0, 0};
    tv[5] = '{1, 32'h0000_0155, 1, 32'h0003_00AA, 1, 1, 0};

    // reset, then idle
    @(posedge mem_clk); #1;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #4; chk("idle_fb_addr", fb_addr, 32'h0); step();

    foreach (tv[i]) begin
      drv(tv[i].dr, tv[i].da, tv[i].pr, tv[i].pa, tv[i].h);
      #4;
      chk("tbl_disp_gnt", 32'(disp_gnt), 32'(tv[i].edg));
      chk("tbl_proc_gnt", 32'(proc_gnt), 32'(tv[i].epg));
      step();
      drv(0, 0, 0, 0, 0);
      tick(); tick(); tick();
    end

    // single display read with forced memory data
    drv(1, 32'h0004_0008, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0); ovr_en = 1'b1; ovr_val = 9'h1A5; tick();
    ovr_en = 1'b0;
    #4;
    chk("d1a5_valid", 32'(disp_valid), 32'd1);
    chk("d1a5_q", 32'(disp_q), 32'h1A5);
    chk("d1a5_pvalid", 32'(proc_valid), 32'd0);
    step(); tick();

    // interleaved disp/proc/disp
    drv(1, 32'h0000_1234, 0, 0, 0); tick();
    drv(0, 0, 1, 32'h0002_0ABC, 0); tick();
    drv(1, 32'h0100_0777, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0);
    #4;
    chk("il_pvalid", 32'(proc_valid), 32'd1);
    chk("il_pq", 32'(proc_q), 32'(mem_rd(32'h0002_0ABC)));
    chk("il_dvalid", 32'(disp_valid), 32'd0);
    step(); tick(); tick();

    // both requesters held high
    npg = 0; first = -1; second = -1;
    drv(1, 32'h0000_0A0A, 1, 32'h0000_0B0B, 0);
    for (int i = 0; i < 20; i++) begin
      #4;
      if (proc_gnt) begin
        npg++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      step();
    end
    chk("starve_nproc", 32'(npg), GUARD ? 32'd2 : 32'd0);
    chk("starve_first", 32'(first), GUARD ? 32'd8 : 32'hFFFF_FFFF);
    chk("starve_second", 32'(second), GUARD ? 32'd17 : 32'hFFFF_FFFF);
    drv(0, 0, 0, 0, 0); tick(); tick(); tick();

    // proc held off for 30 cycles, then released
    seen = 0;
    drv(0, 0, 1, 32'h0000_0C0C, 1);
    for (int i = 0; i < 30; i++) begin #4; seen += int'(proc_gnt) + int'(disp_gnt); step(); end
    chk("hold_nogrant", 32'(seen), 32'd0);
    drv(0, 0, 1, 32'h0000_0C0C, 0);
    #4; chk("hold_release", 32'(proc_gnt), 32'd1); step();
    drv(1, 32'h0000_0D0D, 1, 32'h0000_0C0C, 1);
    for (int i = 0; i < 30; i++) tick();
    drv(1, 32'h0000_0D0D, 1, 32'h0000_0C0C, 0);
    #4; chk("hold_cnt_clr", 32'(proc_gnt), 32'd0); step();
    for (int i = 0; i < 10; i++) tick();
    drv(0, 0, 0, 0, 0); tick(); tick(); tick();

    // reset with reads in flight
    drv(1, 32'h0000_1111, 0, 0, 0); tick();
    drv(1, 32'h0000_2222, 0, 0, 0); tick();
    drv(1, 32'h0000_3333, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0); rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin #4; nv += int'(disp_valid) + int'(proc_valid); step(); end
    chk("rst_inflight_valid", 32'(nv), 32'd0);

    // random traffic; requesters hold req/addr until granted
    dr = 0; pr = 0; da = '0; pa = '0; h = 0;
    for (int i = 0; i < 400; i++) begin
      if (!dr || last_dg) begin dr = ($urandom_range(0, 9) < 6); da = $urandom; end
      if (!pr || last_pg) begin pr = ($urandom_range(0, 9) < 6); pa = $urandom; end
      h = ($urandom_range(0, 9) < 2);
      drv(dr, da, pr, pa, h);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
